fir_out_capture: RTL

// Hardware capture buffer on the output side of the FIR filter. It accepts one filter_out sample per clock.

---
 rtl/fir_out_capture.sv | 107 ++++++++++
 1 files changed

// File: rtl/fir_out_capture.sv
// Capture buffer behind the FIR filter: after an arm pulse it skips a settling run,
// stores a burst of samples in RAM, and tracks their signed min/max. Registered read port.
module fir_out_capture #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int SKIP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SKIP_W-1:0] skip_len,
  input  logic [ADDR_W:0]   cap_len,
  input  logic [DATA_W-1:0] sample_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   cap_count,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  state_t            state, state_nxt;
  logic [SKIP_W-1:0] skip_rem;
  logic [ADDR_W:0]   cap_target;
  logic [ADDR_W:0]   cap_len_eff;
  logic [ADDR_W:0]   cap_count_inc;
  logic              arm;
  logic              wr_en;
  logic              last_wr;
  logic [DATA_W-1:0] mem [DEPTH];

  // Zero and oversize lengths both mean one full buffer; the write pointer never wraps.
  assign cap_len_eff   = (cap_len == '0 || cap_len > DEPTH_C) ? DEPTH_C : cap_len;
  assign cap_count_inc = cap_count + (ADDR_W+1)'(1);
  assign arm           = start && (state == IDLE || state == DONE);
  assign wr_en         = (state == CAPTURE);
  assign last_wr       = wr_en && (cap_count_inc == cap_target);

  assign busy = (state == SKIP) || (state == CAPTURE);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (skip_len == '0) ? CAPTURE : SKIP;
      SKIP:       if (skip_rem == SKIP_W'(1)) state_nxt = CAPTURE;
      CAPTURE:    if (last_wr) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip_rem   <= '0;
      cap_target <= '0;
      cap_count  <= '0;
      peak_max   <= '0;
      peak_min   <= '0;
    end else if (arm) begin
      skip_rem   <= skip_len;
      cap_target <= cap_len_eff;
      cap_count  <= '0;
      peak_max   <= MOST_NEG;
      peak_min   <= MOST_POS;
    end else begin
      if (state == SKIP) skip_rem <= skip_rem - SKIP_W'(1);
      if (wr_en) begin
        cap_count <= cap_count_inc;
        if ($signed(sample_in) > $signed(peak_max)) peak_max <= sample_in;
        if ($signed(sample_in) < $signed(peak_min)) peak_min <= sample_in;
      end
    end
  end

  // NOTE: the RAM has no reset so it maps onto block memory; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cap_count[ADDR_W-1:0]] <= sample_in;
  end

  // Reading mem here sees the pre-edge contents, giving read-before-write on a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule
